// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier feeding HI/LO (MULTU; MULT with SIGNED_MULT_EN).
// Ports: clk, rst_n (async, active-low), start, op_a, op_b -> busy, done, hi, lo.
// Each RUN step adds the multiplicand into the upper product half through a
// WIDTH-bit ripple of full_adder cells, then shifts the product right by one
// with the adder carry entering the MSB.
// Optional feature macro: SIGNED_MULT_EN (two's complement operands, FIX state).

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIGNED_MULT_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   upper;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH:0]     carry;
    logic [2*WIDTH-1:0] shifted;

    assign upper    = prod[2*WIDTH-1:WIDTH];
    assign addend   = prod[0] ? mcand : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a   (upper[i]),
            .b   (addend[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

    // Carry-out is kept: it becomes the new MSB after the shift.
    assign shifted = {carry[WIDTH], sum, prod[WIDTH-1:1]};

`ifdef SIGNED_MULT_EN
    logic               sign;
    logic [2*WIDTH-1:0] fixed;

    // -2^(W-1) maps to the unsigned value 2^(W-1), so no special case.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    assign fixed = sign ? (~prod + 1'b1) : prod;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            prod  <= '0;
            mcand <= '0;
`ifdef SIGNED_MULT_EN
            sign  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
`ifdef SIGNED_MULT_EN
                        mcand <= mag(op_a);
                        prod  <= {{WIDTH{1'b0}}, mag(op_b)};
                        sign  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
`else
                        mcand <= op_a;
                        prod  <= {{WIDTH{1'b0}}, op_b};
`endif
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    prod  <= shifted;
                    count <= count + 1'b1;
                    if (count == LAST) begin
`ifdef SIGNED_MULT_EN
                        state <= FIX;
`else
                        state <= DONE;
                        done  <= 1'b1;
                        hi    <= shifted[2*WIDTH-1:WIDTH];
                        lo    <= shifted[WIDTH-1:0];
`endif
                    end
                end
`ifdef SIGNED_MULT_EN
                FIX: begin
                    state <= DONE;
                    done  <= 1'b1;
                    hi    <= fixed[2*WIDTH-1:WIDTH];
                    lo    <= fixed[WIDTH-1:0];
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=32), unsigned or signed build.
// Expected products are hand-computed constants.

module tb_seq_multiplier;
    localparam int W = 32;
`ifdef SIGNED_MULT_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op_a (op_a),
        .op_b (op_b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply; inj > 0 pulses a second (ignored) start at
    // that RUN cycle with 9*9. Holding of the previous result is checked
    // mid-run against prev.
    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [63:0] exp,
                          input logic [63:0] prev, input int inj);
        int cyc;
        int busy_cnt;
        int done_cnt;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        step();
        start    = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        done_cnt = 0;
        while (!done && cyc < 200) begin
            if (busy) busy_cnt++;
            if (cyc == 5) check({tag, " hold"}, {hi, lo}, prev);
            if (inj > 0 && cyc == inj) begin
                start = 1'b1;
                op_a  = 9;
                op_b  = 9;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(LAT));
        check({tag, " result"}, {hi, lo}, exp);
        while (busy && cyc < 200) begin
            busy_cnt++;
            if (done) done_cnt++;
            step();
            cyc++;
        end
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(LAT + 1));
        check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " idle done"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        step();
        step();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        step();

        run_op("3x5", 3, 5, 64'd15, 64'd0, 0);
`ifdef SIGNED_MULT_EN
        run_op("ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 64'd15, 0);
        run_op("7x6 inj", 7, 6, 64'd42, 64'd1, 10);
`else
        run_op("ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF,
               64'hFFFFFFFE_00000001, 64'd15, 0);
        run_op("7x6 inj", 7, 6, 64'd42, 64'hFFFFFFFE_00000001, 10);
`endif

        // Abort mid-run with reset.
        start = 1'b1;
        op_a  = 32'h12345678;
        op_b  = 32'h10;
        step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("pre-rst busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst hilo", {hi, lo}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        step();
        run_op("2x2", 2, 2, 64'd4, 64'd0, 0);
        run_op("big", 32'h12345678, 32'h10, 64'h00000001_23456780, 64'd4, 0);

`ifdef SIGNED_MULT_EN
        run_op("-3x5", 32'hFFFFFFFD, 5, 64'hFFFFFFFF_FFFFFFF1,
               64'h00000001_23456780, 0);
        run_op("min x -1", 32'h80000000, 32'hFFFFFFFF,
               64'h00000000_80000000, 64'hFFFFFFFF_FFFFFFF1, 0);
        run_op("b2b", 0, 32'hDEADBEEF, 64'd0, 64'h00000000_80000000, 0);
`else
        run_op("ffxff2", 32'hFFFFFFFF, 32'hFFFFFFFF,
               64'hFFFFFFFE_00000001, 64'h00000001_23456780, 0);
        run_op("b2b", 0, 32'hDEADBEEF, 64'd0, 64'hFFFFFFFE_00000001, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Multi-cycle shift-add multiplier for the Mini-MIPS MULT/MULTU path. It writes the 2*WIDTH-bit product into HI/LO.
Each step adds the multiplicand into the running upper partial product through a WIDTH-bit ripple chain of full_adder cells. It then shifts the product register right by one.
It sits between the ID/EX operand registers and the HI/LO register file. It is a downstream consumer of the adder cell and drives the EX-stage stall through busy.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a multiply; sampled only in IDLE
op_a  input  WIDTH  multiplicand; captured on the accepted start
op_b  input  WIDTH  multiplier; captured on the accepted start
busy  output  1  high from the cycle after an accepted start until the state returns to IDLE; the EX stage stalls on it
done  output  1  single-cycle pulse when hi/lo carry a new result
hi  output  WIDTH  upper product half; holds its value until the next completion
lo  output  WIDTH  lower product half; holds its value until the next completion

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset takes effect immediately when asserted, including mid-operation.
  - Reset forces: state=IDLE, busy=0, done=0, hi=0, lo=0, count=0, internal product/multiplicand registers=0.
- States: IDLE, RUN, DONE (plus FIX when SIGNED_MULT_EN is defined).
- IDLE: busy=0, done=0.
  - On an edge with start=1: mcand<=op_a; prod<={WIDTH'b0, op_b}; carry<=0; count<=0; go to RUN.
- RUN: busy=1. Every edge:
  - If prod[0]=1: {c, sum} = prod[2W-1:W] + mcand, a WIDTH-bit ripple of full_adder cells with cin=0. Otherwise {c, sum} = {0, prod[2W-1:W]}.
  - prod <= {c, sum, prod[W-1:1]}, a logical right shift with the adder carry entering the MSB.
  - count <= count+1.
  - When count reaches WIDTH-1 on this edge, go to DONE and load hi/lo from the shifted value on the same edge.
- DONE: busy=1, done=1 for exactly one cycle; next edge goes to IDLE.
- Latency: start accepted at edge 0 -> done high in the cycle after edge WIDTH (WIDTH+1 cycles from start to done inclusive).
  - Back-to-back: start may be asserted in the cycle after done (IDLE) and is accepted.
- start while busy=1 (RUN/DONE/FIX) is ignored, with no queuing. Changes on op_a/op_b during RUN have no effect.
- Carry: the ripple carry-out is never lost; it is shifted into bit 2W-1. The product is exact for all unsigned inputs, with no overflow.
- hi/lo are written only on the transition into DONE. They hold the previous result throughout RUN.
- count width: clog2(WIDTH)+1 bits; no wrap occurs within an operation.
- Reset mid-operation: the operation is abandoned, hi/lo clear to 0, and no done pulse is produced.

Optional Feature:
Macro: SIGNED_MULT_EN.
- Defined: operands are two's complement (MULT semantics).
  - On accept: mcand<=|op_a|, multiplier<=|op_b|, sign<=op_a[W-1]^op_b[W-1].
  - RUN proceeds as for unsigned operands. After RUN, the block enters FIX for one cycle (busy=1): if sign=1 the product is negated (~prod+1 across 2W bits); hi/lo are loaded there.
  - Then DONE. Latency is WIDTH+2 cycles.
  - The magnitude of -2^(W-1) is taken as the unsigned value 2^(W-1), so the result stays exact.
- Undefined: unsigned only (MULTU semantics), there is no FIX state, and latency is WIDTH+1.

Test Plan:
1. Reset, then start with op_a=3, op_b=5 (WIDTH=32) -> busy high for 33 cycles, done pulses once 33 cycles after the accepting edge, hi=0x00000000, lo=0x0000000F.
2. op_a=0xFFFFFFFF, op_b=0xFFFFFFFF (unsigned build) -> hi=0xFFFFFFFE, lo=0x00000001; exercises the carry-out into the MSB on every step.
3. Start a 7*6 multiply; pulse start with op_a=9, op_b=9 at cycle 10 of RUN -> second request ignored, result hi=0, lo=42, single done pulse.
4. Start 0x12345678*0x10; deassert rst_n at cycle 15 for 2 cycles -> busy=0, hi=lo=0 immediately, no done. Then a new 2*2 request -> lo=4.
5. SIGNED_MULT_EN build: op_a=0xFFFFFFFD (-3), op_b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, done at cycle 34. op_a=0x80000000, op_b=0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
6. Back-to-back: assert start in the cycle after done with op_a=0, op_b=0xDEADBEEF -> accepted, hi=lo=0; the previous result is held on hi/lo until the new done.
